i2c_regbank_arbiter: RTL

Shared 16×8 register bank with a two-port arbiter: requester A is the I2C target engine, requester B is the host-side configuration port driven from `ui_in`/`uio_in`. The block serialises all reads and writes to the bank with a req/ack handshake and round-robin fairness. It lets A lock the bank for multi-byte I2C bursts. It sits inside the user project, between the I2C engine, the pin-level config logic and the registers that drive `uo_out`.

---
 rtl/i2c_regbank_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/i2c_regbank_arbiter.sv
// rtl/i2c_regbank_arbiter.sv - shared 16x8 register bank behind a two-port round-robin arbiter with burst lock
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   ena                    grant enable; an access already granted always completes
//   a_req/a_we/a_addr/a_wdata/a_lock   requester A (I2C target engine) request
//   a_ack, a_rdata         requester A completion pulse and held read data
//   b_req/b_we/b_addr/b_wdata          requester B (host config port) request
//   b_ack, b_rdata         requester B completion pulse and held read data
//   busy                   high while an access is in ACCESS or ACK
//   owner                  current or most recent grantee (0 = A, 1 = B)
//   locked                 bank locked to A for a multi-byte burst
module i2c_regbank_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic              a_lock,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              busy,
   output logic              owner,
   output logic              locked
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                owner_q;
   logic                locked_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
   logic [DATA_W-1:0]   bank [DEPTH];

   logic                elig_a, elig_b;
   logic                grant;
   logic                grant_b;

   // B is held off entirely while A owns the burst lock.
   assign elig_a = a_req;
   assign elig_b = b_req & ~locked_q;

   // On a tie the port that did not own the previous access wins.
   assign grant_b = elig_b & (~elig_a | ~owner_q);

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ena && (elig_a || elig_b)) begin
               grant   = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS:  state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= 1'b1;
         locked_q  <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            bank[i] <= '0;
         end
      end else begin
         state_q <= state_d;

         if (grant) begin
            owner_q <= grant_b;
            we_q    <= grant_b ? b_we    : a_we;
            addr_q  <= grant_b ? b_addr  : a_addr;
            wdata_q <= grant_b ? b_wdata : a_wdata;
         end

         // Bank write and read capture both land at the end of ACCESS.
         if (state_q == ACCESS) begin
            if (we_q) begin
               bank[addr_q] <= wdata_q;
            end else if (owner_q) begin
               b_rdata_q <= bank[addr_q];
            end else begin
               a_rdata_q <= bank[addr_q];
            end
         end

         if (state_q == ACK && !owner_q) begin
            locked_q <= a_lock;
         end
      end
   end

   assign a_ack   = (state_q == ACK) & ~owner_q;
   assign b_ack   = (state_q == ACK) &  owner_q;
   assign a_rdata = a_rdata_q;
   assign b_rdata = b_rdata_q;
   assign busy    = (state_q != IDLE);
   assign owner   = owner_q;
   assign locked  = locked_q;

endmodule
